// File: rtl/console_ctrl.sv
// console_ctrl: byte FIFO between the core's console writes and a valid/ready byte sink.
// When full it either stalls the core or drops the write and counts the loss.
module console_ctrl #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 16,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    console_we,
    input  logic [XLEN-1:0]         console_wdata,
    output logic                    stall,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = console_we && !w_full;
    assign w_pop   = !w_empty && tx_ready;

    // Storage is not reset; validity is tracked by r_level alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= console_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // First-word fall-through head; reads as zero while empty.
    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign level    = r_level;

    generate
        if (XLEN > 8) begin : g_hi_unused
            logic w_unused_hi;
            assign w_unused_hi = ^console_wdata[XLEN-1:8];
        end

        if (DROP_ON_FULL) begin : g_drop
            logic        w_drop;
            logic [15:0] r_drop_count;
            logic        r_overflow;

            assign w_drop = console_we && w_full;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_drop_count <= '0;
                    r_overflow   <= 1'b0;
                end else if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_count != 16'hFFFF) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                end
            end

            assign stall      = 1'b0;
            assign drop_count = r_drop_count;
            assign overflow   = r_overflow;
        end else begin : g_stall
            assign stall      = w_full;
            assign drop_count = 16'h0000;
            assign overflow   = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_console_ctrl.sv
// Bench for console_ctrl: a stall-mode and a drop-mode instance share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_console_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        console_we;
    logic [31:0] console_wdata;
    logic        tx_ready;

    logic        s_stall, s_valid, s_ovf;
    logic [7:0]  s_data;
    logic [4:0]  s_level;
    logic [15:0] s_dcnt;
    logic        d_stall, d_valid, d_ovf;
    logic [7:0]  d_data;
    logic [4:0]  d_level;
    logic [15:0] d_dcnt;

    always #5 clk = ~clk;

    console_ctrl #(.XLEN(32), .DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) u_stall (
        .clk(clk), .reset_n(reset_n), .console_we(console_we), .console_wdata(console_wdata),
        .stall(s_stall), .tx_valid(s_valid), .tx_data(s_data), .tx_ready(tx_ready),
        .level(s_level), .drop_count(s_dcnt), .overflow(s_ovf)
    );

    console_ctrl #(.XLEN(32), .DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) u_drop (
        .clk(clk), .reset_n(reset_n), .console_we(console_we), .console_wdata(console_wdata),
        .stall(d_stall), .tx_valid(d_valid), .tx_data(d_data), .tx_ready(tx_ready),
        .level(d_level), .drop_count(d_dcnt), .overflow(d_ovf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of the FIFO as a queue, plus the drop-mode counters.
    byte unsigned q[$];
    int           m_dcnt;
    bit           m_ovf;
    byte unsigned got_s[$];
    byte unsigned got_d[$];

    typedef struct {
        bit          we;
        logic [31:0] wd;
        bit          rdy;
        bit          ev;
        logic [7:0]  ed;
        int          el;
    } vec_t;
    vec_t tv[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        int exp_data;
        int n;
        n = q.size();
        exp_data = (n != 0) ? int'(q[0]) : 0;
        chk("s_valid", int'(s_valid), int'(n != 0));
        chk("s_data",  int'(s_data),  exp_data);
        chk("s_level", int'(s_level), n);
        chk("s_stall", int'(s_stall), int'(n == DEPTH));
        chk("s_dcnt",  int'(s_dcnt),  0);
        chk("s_ovf",   int'(s_ovf),   0);
        chk("d_valid", int'(d_valid), int'(n != 0));
        chk("d_data",  int'(d_data),  exp_data);
        chk("d_level", int'(d_level), n);
        chk("d_stall", int'(d_stall), 0);
        chk("d_dcnt",  int'(d_dcnt),  m_dcnt);
        chk("d_ovf",   int'(d_ovf),   int'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        got_s.delete();
        got_d.delete();
        m_dcnt = 0;
        m_ovf  = 1'b0;
    endtask

    // Called at a negedge: drive inputs, step the model, let the edge pass, then compare.
    task automatic cycle(input bit we, input logic [31:0] wd, input bit rdy);
        bit full;
        console_we    = we;
        console_wdata = wd;
        tx_ready      = rdy;
        #1;
        if (rdy && s_valid) got_s.push_back(s_data);
        if (rdy && d_valid) got_d.push_back(d_data);
        full = (q.size() == DEPTH);
        if (rdy && q.size() != 0) void'(q.pop_front());
        if (we && !full) q.push_back(wd[7:0]);
        if (we && full) begin
            m_ovf = 1'b1;
            if (m_dcnt < 65535) m_dcnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        console_we    = 1'b0;
        console_wdata = 32'h0;
        tx_ready      = 1'b0;
        reset_n       = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (s_valid && k < budget) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("drain_done", int'(s_valid), 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        console_we    = 1'b0;
        console_wdata = 32'h0;
        tx_ready      = 1'b0;
        model_reset();

        // Reset then idle with the sink ready.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
        $display("idle: level=%0d valid=%0b stall=%0b", s_level, s_valid, s_stall);

        // "Hi\n" through an always-ready sink; upper data bits must be ignored.
        tv[0] = '{we: 1'b1, wd: 32'hDEAD_BE48, rdy: 1'b1, ev: 1'b1, ed: 8'h48, el: 1};
        tv[1] = '{we: 1'b1, wd: 32'h1234_5669, rdy: 1'b1, ev: 1'b1, ed: 8'h69, el: 1};
        tv[2] = '{we: 1'b1, wd: 32'hFFFF_FF0A, rdy: 1'b1, ev: 1'b1, ed: 8'h0A, el: 1};
        tv[3] = '{we: 1'b0, wd: 32'h0000_0000, rdy: 1'b1, ev: 1'b0, ed: 8'h00, el: 0};
        for (int i = 0; i < 4; i++) begin
            cycle(tv[i].we, tv[i].wd, tv[i].rdy);
            chk("tv_valid", int'(s_valid), int'(tv[i].ev));
            chk("tv_data",  int'(s_data),  int'(tv[i].ed));
            chk("tv_level", int'(s_level), tv[i].el);
            $display("vec %0d: we=%0b wd=%08h -> valid=%0b data=%02h level=%0d",
                     i, tv[i].we, tv[i].wd, s_valid, s_data, s_level);
        end

        // Stall mode: fill 16, hold the 17th, then drain across the pointer wrap.
        do_reset();
        for (int b = 0; b < 16; b++) cycle(1'b1, 32'(b), 1'b0);
        chk("fill_stall", int'(s_stall), 1);
        chk("fill_level", int'(s_level), 16);
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h10, 1'b0);
        chk("held_level", int'(s_level), 16);
        cycle(1'b1, 32'h10, 1'b1);
        chk("full_pop_level", int'(s_level), 15);
        cycle(1'b1, 32'h10, 1'b1);
        chk("retry_level", int'(s_level), 15);
        drain(40);
        chk("stall_count", got_s.size(), 17);
        for (int i = 0; i < 17 && i < got_s.size(); i++) chk("stall_order", int'(got_s[i]), i);
        $display("stall fill: drained %0d bytes", got_s.size());

        // Drop mode: 20 writes into a stalled sink.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
        chk("drop_level", int'(d_level), 16);
        chk("drop_count", int'(d_dcnt), 4);
        chk("drop_ovf",   int'(d_ovf), 1);
        drain(40);
        chk("drop_drained", got_d.size(), 16);
        for (int i = 0; i < 16 && i < got_d.size(); i++) chk("drop_order", int'(got_d[i]), 'hA0 + i);
        cycle(1'b0, 32'h0, 1'b0);
        chk("ovf_sticky", int'(d_ovf), 1);
        $display("drop: drop_count=%0d overflow=%0b", d_dcnt, d_ovf);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h30 + 32'(i), 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(s_valid), 0);
        chk("arst_level", int'(s_level), 0);
        chk("arst_dvalid", int'(d_valid), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 32'h41, 1'b0);
        chk("arst_next", int'(s_data), 'h41);
        $display("async reset: next byte=%02h", s_data);

        // Randomised traffic with alternating sink speed to reach both full and empty.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int thr;
            thr = ((i / 60) % 2 == 0) ? 25 : 85;
            cycle(($urandom_range(0, 99) < 70), $urandom(), ($urandom_range(0, 99) < thr));
        end
        $display("random: final level=%0d drops=%0d", d_level, d_dcnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
